// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared FSM states and gate-length helper for the frequency meter
package freq_meter_pkg;
    typedef enum logic {IDLE, GATE} state_t;
    function automatic logic [31:0] gate_len(input logic [31:0] base, input logic [1:0] sel);
        return base >> sel;
    endfunction
endpackage

// File: rtl/freq_meter_array_if.sv
// freq_meter_array_if: pulse inputs, window control and latched result bus of the meter
interface freq_meter_array_if #(
    parameter int CHANNELS = 8,
    parameter int CNT_W = 24
);
    logic [CHANNELS-1:0] sig_in;
    logic enable;
    logic [1:0] gate_sel;
    logic [CHANNELS*CNT_W-1:0] freq_out;
    logic [CHANNELS-1:0] ovf_out;
    logic update;
    logic busy;
    modport master (output sig_in, enable, gate_sel, input freq_out, ovf_out, update, busy);
    modport slave (input sig_in, enable, gate_sel, output freq_out, ovf_out, update, busy);
endinterface

// File: rtl/freq_chan.sv
// freq_chan: one channel -- synchroniser, rise detect, saturating edge counter with overflow flag
module freq_chan #(
    parameter int CNT_W = 24,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst,
    input logic sig,
    input logic clear,
    input logic last,
    output logic [CNT_W-1:0] result,
    output logic ovf
);
    logic [SYNC_STAGES-1:0] sync;
    logic sync_d;
    logic [CNT_W-1:0] cnt;
    logic flag;
    logic rise;
    logic sat;
    assign rise = sync[SYNC_STAGES-1] & ~sync_d;
    assign sat = &cnt;
    // result already includes this cycle's rise so a boundary rise lands in the closing window
    assign result = cnt + CNT_W'(rise && !sat);
    assign ovf = flag | (rise & sat);
    // synchronise the input, count rises, restart at window end or while idle/aborting
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync <= '0;
            sync_d <= 1'b0;
            cnt <= '0;
            flag <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig};
            sync_d <= sync[SYNC_STAGES-1];
            if (clear || last) begin
                cnt <= '0;
                flag <= 1'b0;
            end else if (rise) begin
                cnt <= result;
                flag <= ovf;
            end
        end
endmodule

// File: rtl/freq_meter_array.sv
// freq_meter_array: N-channel frequency meter with common gate window and latched export bus
module freq_meter_array
    import freq_meter_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int CNT_W = 24,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input logic clk_clk,
    input logic reset_reset,
    freq_meter_array_if.slave bus
);
    state_t state, next;
    logic [31:0] gate_cnt;
    logic [31:0] win_len;
    logic last;
    logic clear;
    logic [CHANNELS*CNT_W-1:0] result;
    logic [CHANNELS-1:0] ovf;
    assign last = state == GATE && gate_cnt == win_len - 32'd1;
    assign clear = state == IDLE || !bus.enable;
    assign bus.busy = state == GATE;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        freq_chan #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_chan (
            .clk(clk_clk),
            .rst(reset_reset),
            .sig(bus.sig_in[i]),
            .clear(clear),
            .last(last),
            .result(result[i*CNT_W +: CNT_W]),
            .ovf(ovf[i])
        );
    end
    // state register
    always_ff @(posedge clk_clk or posedge reset_reset)
        if (reset_reset) state <= IDLE;
        else state <= next;
    // windows run back to back while enabled; dropping enable ends or aborts the window
    always_comb begin
        next = IDLE;
        if (bus.enable) next = GATE;
    end
    // gate counter; window length is sampled only when a window starts
    always_ff @(posedge clk_clk or posedge reset_reset)
        if (reset_reset) begin
            gate_cnt <= '0;
            win_len <= 32'(GATE_CYCLES);
        end else begin
            gate_cnt <= (clear || last) ? '0 : gate_cnt + 32'd1;
            if (state == IDLE || last) win_len <= gate_len(32'(GATE_CYCLES), bus.gate_sel);
        end
    // publish results and pulse update the cycle after the last window cycle
    always_ff @(posedge clk_clk or posedge reset_reset)
        if (reset_reset) begin
            bus.freq_out <= '0;
            bus.ovf_out <= '0;
            bus.update <= 1'b0;
        end else begin
            bus.update <= last;
            if (last) begin
                bus.freq_out <= result;
                bus.ovf_out <= ovf;
            end
        end
endmodule

// File: doc/freq_meter_array.md
# freq_meter_array

Parametrised N-channel frequency meter, the successor to the fixed eight-channel 24-bit frequency inputs of the sensor core. Each channel synchronises an external pulse input, counts rising edges over a common gate window, and presents the latched count on a flat export bus for a PIO/Avalon wrapper. Additions over the previous generation: configurable channel count, counter width and gate length, a run-time gate divider, per-channel overflow flags, and back-to-back windows with no dead time.

## Interface
- CHANNELS, 8, number of measured inputs (1–32)
- CNT_W, 24, edge counter / result width per channel
- GATE_CYCLES, 50_000_000, base gate length in clk_clk cycles (1 s at 50 MHz); must be ≥ 16
- SYNC_STAGES, 2, input synchroniser depth (≥ 2)

- clk_clk  in  1  system clock
- reset_reset  in  1  asynchronous, active-high reset
- sig_in  in  CHANNELS  asynchronous pulse inputs, bit i = channel i
- enable  in  1  run measurement windows while high
- gate_sel  in  2  gate divider: window = GATE_CYCLES >> gate_sel
- freq_out  out  CHANNELS*CNT_W  latched counts, channel i at [i*CNT_W +: CNT_W]
- ovf_out  out  CHANNELS  latched per-channel saturation flag for the last window
- update  out  1  one-cycle pulse when freq_out/ovf_out are refreshed
- busy  out  1  high while a window is open

## Operation
- Per channel: SYNC_STAGES flop synchroniser, then a one-flop delay for edge detection; `rise = sync & ~sync_d`.
- FSM states: IDLE, GATE.
  - IDLE: counters at 0, busy=0. On enable=1, sample gate_sel into win_len = GATE_CYCLES >> gate_sel, clear gate_cnt, go to GATE.
  - GATE: gate_cnt increments each cycle; each channel counter increments on rise.
  - Last window cycle (gate_cnt == win_len−1): for each channel, result = counter + rise (saturating) goes to freq_out. The cycle's overflow state goes to ovf_out. Counters reset to 0 and update is asserted next cycle. If enable is still 1, gate_sel is resampled, gate_cnt clears and the state stays GATE with no gap; otherwise the FSM goes to IDLE.
  - enable falling mid-window: abort at the next edge; counters and gate_cnt are cleared, IDLE is entered, no update, freq_out/ovf_out hold their previous values.
- Saturation: a counter stops at 2^CNT_W−1. Its overflow bit sets on any rise that arrives while the counter is saturated, including the boundary-cycle rise. The overflow bit clears with the counter.
- gate_sel changes mid-window take effect only at the next window start.
- Each rising edge is counted in exactly one window. A rise on the last cycle belongs to the closing window.

## Timing
- Reset values: freq_out=0, ovf_out=0, update=0, busy=0, FSM=IDLE, all counters and synchronisers 0.
- Input-to-count latency: SYNC_STAGES+1 cycles from sig_in edge to counter increment.
- busy rises 1 cycle after enable is sampled high in IDLE.
- update pulses 1 cycle after the last window cycle, coincident with the new freq_out values.
- Consecutive updates are exactly win_len cycles apart while enable stays high.
- Maximum countable input frequency: clk_clk/2.
- reset_reset mid-window: immediate return to reset values; no partial result is published.

## Structure
- Shared package freq_meter_pkg holds the FSM state enum (IDLE, GATE) and the gate-length function (GATE_CYCLES >> sel).
- Sub-module freq_chan: synchroniser, edge detect, saturating counter and overflow flag for one channel. It has inputs clear/last and outputs result/ovf, and is instantiated CHANNELS times by generate.
- The top level holds the FSM, gate counter, output registers and update pulse.

## Test plan
- Bench params CHANNELS=4, CNT_W=8, GATE_CYCLES=100, gate_sel=0: ch0 period 10 cycles, ch1 period 4, ch2 constant 0 -> update every 100 cycles. After the first full window: ch0=10, ch1=25, ch2=0, ovf=0.
- CNT_W=4, ch0 period 4 over a 100-cycle window -> ch0=15, ovf_out[0]=1. Next window with ch0 idle -> 0, ovf cleared.
- gate_sel=2 -> window 25 cycles; ch0 period 5 -> 5 per window. gate_sel changed mid-window -> new length only from the following window.
- enable dropped at cycle 50 of a window -> no update, freq_out holds the prior value, busy=0 next cycle. Re-enable -> fresh 100-cycle window.
- Rise timed to reach the counter exactly on the last window cycle -> counted once, in the closing window only. The total over two windows equals the total edges applied.
- reset_reset asserted mid-window -> all outputs 0 asynchronously. After release with enable=1, the first update occurs 101 cycles later.
